// File: rtl/cmsdk_mcu_ahb_slave_mux_pkg.sv
// ----------------------------------------------------------------------------
// cmsdk_mcu_ahb_pkg
// Shared definitions for the CPU AHB-Lite data-phase response mux:
//   - HTRANS encodings
//   - slot indices for the decoder select vector (default slave is the top slot)
//   - default-slave FSM state encoding
// ----------------------------------------------------------------------------
package cmsdk_mcu_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam int SLOT_FLASH  = 0;
  localparam int SLOT_DMA    = 1;
  localparam int SLOT_SDRAM  = 2;
  localparam int SLOT_APBBUS = 3;
  localparam int SLOT_CPU2   = 4;
  localparam int SLOT_DEF    = 5;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

endpackage

// File: rtl/cmsdk_mcu_ahb_slave_mux_if.sv
// ----------------------------------------------------------------------------
// cmsdk_mcu_ahb_slave_mux_if
// Bus bundle between the address decoder / slaves and the response mux.
//   slave  modport : the mux side (takes address phase + slave responses,
//                    returns the muxed response to the master)
//   master modport : the environment side driving the mux
// Signals:
//   haddr, htrans, hready          address-phase bus signals
//   hsel_vec, defslv_hsel          decoder selects (external slots / unmapped)
//   slv_hrdata/hreadyout/hresp     per-slave data-phase responses
//   hrdata, hready_out, hresp      muxed response to the master
// ----------------------------------------------------------------------------
interface cmsdk_mcu_ahb_slave_mux_if #(
  parameter int NUM_SLV = 5,
  parameter int DW      = 32
);
  logic [31:0]         haddr;
  logic [1:0]          htrans;
  logic                hready;
  logic [NUM_SLV-1:0]  hsel_vec;
  logic                defslv_hsel;
  logic [NUM_SLV*DW-1:0] slv_hrdata;
  logic [NUM_SLV-1:0]  slv_hreadyout;
  logic [NUM_SLV-1:0]  slv_hresp;
  logic [DW-1:0]       hrdata;
  logic                hready_out;
  logic                hresp;

  modport slave (
    input  haddr, htrans, hready, hsel_vec, defslv_hsel,
    input  slv_hrdata, slv_hreadyout, slv_hresp,
    output hrdata, hready_out, hresp
  );

  modport master (
    output haddr, htrans, hready, hsel_vec, defslv_hsel,
    output slv_hrdata, slv_hreadyout, slv_hresp,
    input  hrdata, hready_out, hresp
  );
endinterface

// File: rtl/cmsdk_mcu_ahb_slave_mux_default_slave.sv
// ----------------------------------------------------------------------------
// cmsdk_mcu_ahb_default_slave
// Built-in default slave for unmapped / invalid selects. Answers every active
// transfer with a two-cycle AHB ERROR and keeps debug state.
// Ports:
//   hclk, hreset     clock, synchronous active-high reset
//   hready, htrans   address-phase qualifiers
//   haddr            address-phase HADDR (captured on an errored transfer)
//   def_sel          address-phase select resolved to the default slot
//   hreadyout, hresp this slave's data-phase response
//   err_count        saturating count of completed ERROR responses
//   err_addr         HADDR of the most recent errored transfer
// ----------------------------------------------------------------------------
module cmsdk_mcu_ahb_default_slave
  import cmsdk_mcu_ahb_pkg::*;
#(
  parameter int ERRCNT_W = 8
) (
  input  logic                hclk,
  input  logic                hreset,
  input  logic                hready,
  input  logic [1:0]          htrans,
  input  logic [31:0]         haddr,
  input  logic                def_sel,
  output logic                hreadyout,
  output logic                hresp,
  output logic [ERRCNT_W-1:0] err_count,
  output logic [31:0]         err_addr
);

  ds_state_e state_q, state_d;
  logic      start;
  logic      addr_load;
  logic      cnt_inc;

  // BUSY and IDLE get a zero-wait OKAY; only NONSEQ/SEQ are errored.
  assign start = hready && def_sel && (htrans inside {HTRANS_NONSEQ, HTRANS_SEQ});

  // NOTE: state and debug registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q   <= DS_IDLE;
      err_count <= '0;
      err_addr  <= '0;
    end else begin
      state_q <= state_d;
      if (addr_load) err_addr <= haddr;
      if (cnt_inc && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

  // NOTE: every output of this block is given a default before the case so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    addr_load = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      DS_IDLE: begin
        if (start) begin
          state_d   = DS_ERR1;
          addr_load = 1'b1;
        end
      end
      DS_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = DS_ERR2;
      end
      DS_ERR2: begin
        hresp   = 1'b1;
        cnt_inc = 1'b1;
        // hready is high here, so a pending active transfer chains straight
        // into the next error without an IDLE gap.
        if (start) begin
          state_d   = DS_ERR1;
          addr_load = 1'b1;
        end else begin
          state_d = DS_IDLE;
        end
      end
      default: state_d = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/cmsdk_mcu_ahb_slave_mux.sv
// ----------------------------------------------------------------------------
// cmsdk_mcu_ahb_slave_mux
// Data-phase response mux downstream of the CPU AHB-Lite address decoder.
// Registers {defslv_hsel, hsel_vec} in the address phase and routes the
// selected slave's HRDATA/HREADYOUT/HRESP to the master in the data phase.
// A non-one-hot select is treated as a default-slave select.
// Ports:
//   hclk, hreset  clock, synchronous active-high reset
//   bus           cmsdk_mcu_ahb_slave_mux_if.slave bus bundle
//   err_count     default-slave saturating error count
//   err_addr      HADDR of the last default-slave errored transfer
// ----------------------------------------------------------------------------
module cmsdk_mcu_ahb_slave_mux
  import cmsdk_mcu_ahb_pkg::*;
#(
  parameter int NUM_SLV  = 5,
  parameter int DW       = 32,
  parameter int ERRCNT_W = 8
) (
  input  logic                  hclk,
  input  logic                  hreset,
  cmsdk_mcu_ahb_slave_mux_if.slave bus,
  output logic [ERRCNT_W-1:0]   err_count,
  output logic [31:0]           err_addr
);

  // Default slot sits just above the external slots.
  localparam int DEF = NUM_SLV;

  logic [NUM_SLV:0] sel_d, sel_q;
  logic             addr_def_sel;
  logic             data_def_sel;
  logic             ds_hreadyout;
  logic             ds_hresp;
  logic [DW-1:0]    hrdata_mux;
  logic             hready_mux;
  logic             hresp_mux;

  assign sel_d        = {bus.defslv_hsel, bus.hsel_vec};
  assign addr_def_sel = !$onehot(sel_d) || sel_d[DEF];
  assign data_def_sel = !$onehot(sel_q) || sel_q[DEF];

  // Capture only when the bus is ready; a stalled data phase keeps its select.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      sel_q      <= '0;
      sel_q[DEF] <= 1'b1;
    end else if (bus.hready) begin
      sel_q <= sel_d;
    end
  end

  cmsdk_mcu_ahb_default_slave #(
    .ERRCNT_W (ERRCNT_W)
  ) u_default_slave (
    .hclk      (hclk),
    .hreset    (hreset),
    .hready    (bus.hready),
    .htrans    (bus.htrans),
    .haddr     (bus.haddr),
    .def_sel   (addr_def_sel),
    .hreadyout (ds_hreadyout),
    .hresp     (ds_hresp),
    .err_count (err_count),
    .err_addr  (err_addr)
  );

  always_comb begin
    hrdata_mux = '0;
    hready_mux = ds_hreadyout;
    hresp_mux  = ds_hresp;
    if (!data_def_sel) begin
      for (int i = 0; i < NUM_SLV; i++) begin
        if (sel_q[i]) begin
          hrdata_mux = bus.slv_hrdata[i*DW +: DW];
          hready_mux = bus.slv_hreadyout[i];
          hresp_mux  = bus.slv_hresp[i];
        end
      end
    end
  end

  assign bus.hrdata     = hrdata_mux;
  assign bus.hready_out = hready_mux;
  assign bus.hresp      = hresp_mux;

endmodule

// File: tb/tb_cmsdk_mcu_ahb_slave_mux.sv
// ----------------------------------------------------------------------------
// tb_cmsdk_mcu_ahb_slave_mux
// Directed bench for the AHB data-phase response mux. Two instances share
// the same stimulus: u_dut with the default 8-bit error counter and u_sat
// with a 2-bit counter to exercise saturation. hready is looped back from
// hready_out as at the system top level.
// ----------------------------------------------------------------------------
module tb_cmsdk_mcu_ahb_slave_mux;
  import cmsdk_mcu_ahb_pkg::*;

  localparam int NUM_SLV = 5;
  localparam int DW      = 32;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [7:0]  err_count;
  logic [31:0] err_addr;
  logic [1:0]  sat_count;
  logic [31:0] sat_addr;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  cmsdk_mcu_ahb_slave_mux_if #(.NUM_SLV(NUM_SLV), .DW(DW)) bus ();
  cmsdk_mcu_ahb_slave_mux_if #(.NUM_SLV(NUM_SLV), .DW(DW)) bus_sat ();

  assign bus.hready = bus.hready_out;

  assign bus_sat.haddr         = bus.haddr;
  assign bus_sat.htrans        = bus.htrans;
  assign bus_sat.hsel_vec      = bus.hsel_vec;
  assign bus_sat.defslv_hsel   = bus.defslv_hsel;
  assign bus_sat.slv_hrdata    = bus.slv_hrdata;
  assign bus_sat.slv_hreadyout = bus.slv_hreadyout;
  assign bus_sat.slv_hresp     = bus.slv_hresp;
  assign bus_sat.hready        = bus_sat.hready_out;

  cmsdk_mcu_ahb_slave_mux #(.NUM_SLV(NUM_SLV), .DW(DW), .ERRCNT_W(8)) u_dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .bus       (bus),
    .err_count (err_count),
    .err_addr  (err_addr)
  );

  cmsdk_mcu_ahb_slave_mux #(.NUM_SLV(NUM_SLV), .DW(DW), .ERRCNT_W(2)) u_sat (
    .hclk      (hclk),
    .hreset    (hreset),
    .bus       (bus_sat),
    .err_count (sat_count),
    .err_addr  (sat_addr)
  );

  // Advance to just after the next rising edge (input drive point).
  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  // Move to the falling edge (output sample point).
  task automatic mid();
    @(negedge hclk);
  endtask

  task automatic idle_inputs(input logic [31:0] addr);
    bus.haddr       = addr;
    bus.htrans      = HTRANS_IDLE;
    bus.hsel_vec    = '0;
    bus.defslv_hsel = 1'b1;
  endtask

  task automatic addr_phase(input logic [NUM_SLV-1:0] sel, input logic def,
                            input logic [1:0] trans, input logic [31:0] addr);
    bus.hsel_vec    = sel;
    bus.defslv_hsel = def;
    bus.htrans      = trans;
    bus.haddr       = addr;
  endtask

  task automatic set_slot(input int slot, input logic [DW-1:0] data);
    bus.slv_hrdata[slot*DW +: DW] = data;
  endtask

  task automatic chk_resp(input string name, input logic rdy, input logic rsp);
    checks++;
    if (bus.hready_out !== rdy || bus.hresp !== rsp) begin
      errors++;
      $display("FAIL %s: hready_out/hresp got %b/%b expected %b/%b",
               name, bus.hready_out, bus.hresp, rdy, rsp);
    end
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    idle_inputs(32'h0);
    bus.slv_hrdata    = '0;
    bus.slv_hreadyout = '1;
    bus.slv_hresp     = '0;
    cyc();
    cyc();
    mid();
    chk_resp("reset_resp", 1'b1, 1'b0);
    checks++;
    if (bus.hrdata !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %h expected 00000000", bus.hrdata); end
    checks++;
    if (err_count !== 8'd0 || err_addr !== 32'h0) begin
      errors++; $display("FAIL reset_err: count %0d addr %h expected 0 00000000", err_count, err_addr);
    end
    cyc();
    hreset = 1'b0;
    mid();
  endtask

  task automatic test_flash_read();
    cyc();
    addr_phase(5'b00001, 1'b0, HTRANS_NONSEQ, 32'h0000_0100);
    mid();
    cyc();
    idle_inputs(32'h0);
    set_slot(SLOT_FLASH, 32'hDEAD_BEEF);
    mid();
    chk_resp("flash_resp", 1'b1, 1'b0);
    checks++;
    if (bus.hrdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL flash_hrdata: got %h expected deadbeef", bus.hrdata); end
  endtask

  task automatic test_sdram_wait();
    cyc();
    addr_phase(5'b00100, 1'b0, HTRANS_NONSEQ, 32'h6000_0000);
    mid();
    // Stall cycles: a flash select is presented but must not be captured.
    for (int w = 0; w < 2; w++) begin
      cyc();
      addr_phase(5'b00001, 1'b0, HTRANS_NONSEQ, 32'h0000_0200);
      bus.slv_hreadyout = 5'b11011;
      mid();
      chk_resp($sformatf("sdram_ws%0d", w), 1'b0, 1'b0);
    end
    cyc();
    bus.slv_hreadyout = '1;
    set_slot(SLOT_SDRAM, 32'h1234_5678);
    mid();
    chk_resp("sdram_done", 1'b1, 1'b0);
    checks++;
    if (bus.hrdata !== 32'h1234_5678) begin errors++; $display("FAIL sdram_hrdata: got %h expected 12345678", bus.hrdata); end
    cyc();
    idle_inputs(32'h0);
    set_slot(SLOT_FLASH, 32'hCAFE_F00D);
    mid();
    checks++;
    if (bus.hrdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL sdram_next_phase: got %h expected cafef00d", bus.hrdata); end
  endtask

  task automatic test_unmapped();
    cyc();
    addr_phase(5'b00000, 1'b1, HTRANS_NONSEQ, 32'h3000_0010);
    mid();
    cyc();
    idle_inputs(32'h3000_0100);
    mid();
    chk_resp("unmapped_err1", 1'b0, 1'b1);
    checks++;
    if (bus.hrdata !== 32'h0) begin errors++; $display("FAIL unmapped_hrdata: got %h expected 00000000", bus.hrdata); end
    cyc();
    mid();
    chk_resp("unmapped_err2", 1'b1, 1'b1);
    cyc();
    mid();
    chk_resp("unmapped_after", 1'b1, 1'b0);
    checks++;
    if (err_count !== 8'd1 || err_addr !== 32'h3000_0010) begin
      errors++; $display("FAIL unmapped_debug: count %0d addr %h expected 1 30000010", err_count, err_addr);
    end
  endtask

  task automatic test_back_to_back();
    cyc();
    addr_phase(5'b00000, 1'b1, HTRANS_NONSEQ, 32'h3000_0010);
    mid();
    cyc();
    addr_phase(5'b00000, 1'b1, HTRANS_SEQ, 32'h3000_0014);
    mid();
    chk_resp("b2b_err1_a", 1'b0, 1'b1);
    cyc();
    mid();
    chk_resp("b2b_err2_a", 1'b1, 1'b1);
    cyc();
    idle_inputs(32'h3000_0020);
    mid();
    chk_resp("b2b_err1_b", 1'b0, 1'b1);
    checks++;
    if (err_count !== 8'd2 || err_addr !== 32'h3000_0014) begin
      errors++; $display("FAIL b2b_mid_debug: count %0d addr %h expected 2 30000014", err_count, err_addr);
    end
    cyc();
    addr_phase(5'b00000, 1'b1, HTRANS_BUSY, 32'h3000_0024);
    mid();
    chk_resp("b2b_err2_b", 1'b1, 1'b1);
    cyc();
    idle_inputs(32'h3000_0028);
    mid();
    chk_resp("busy_okay", 1'b1, 1'b0);
    cyc();
    mid();
    chk_resp("idle_okay", 1'b1, 1'b0);
    checks++;
    if (err_count !== 8'd3 || err_addr !== 32'h3000_0014) begin
      errors++; $display("FAIL b2b_debug: count %0d addr %h expected 3 30000014", err_count, err_addr);
    end
    checks++;
    if (sat_count !== 2'd3) begin errors++; $display("FAIL sat_at_3: got %0d expected 3", sat_count); end
  endtask

  task automatic test_invalid_select();
    cyc();
    addr_phase(5'b00011, 1'b0, HTRANS_NONSEQ, 32'h0000_0200);
    mid();
    cyc();
    idle_inputs(32'h0);
    mid();
    chk_resp("multihot_err1", 1'b0, 1'b1);
    cyc();
    mid();
    chk_resp("multihot_err2", 1'b1, 1'b1);
    cyc();
    mid();
    checks++;
    if (err_count !== 8'd4 || err_addr !== 32'h0000_0200) begin
      errors++; $display("FAIL multihot_debug: count %0d addr %h expected 4 00000200", err_count, err_addr);
    end
  endtask

  task automatic test_saturation();
    cyc();
    addr_phase(5'b00000, 1'b1, HTRANS_NONSEQ, 32'h3000_0030);
    mid();
    cyc();
    idle_inputs(32'h0);
    mid();
    cyc();
    mid();
    cyc();
    mid();
    checks++;
    if (err_count !== 8'd5) begin errors++; $display("FAIL count_5: got %0d expected 5", err_count); end
    checks++;
    if (sat_count !== 2'd3 || sat_addr !== 32'h3000_0030) begin
      errors++; $display("FAIL sat_count: count %0d addr %h expected 3 30000030", sat_count, sat_addr);
    end
  endtask

  task automatic test_slave_error();
    cyc();
    addr_phase(5'b01000, 1'b0, HTRANS_NONSEQ, 32'h4000_0000);
    mid();
    cyc();
    idle_inputs(32'h0);
    bus.slv_hreadyout = 5'b10111;
    bus.slv_hresp     = 5'b01000;
    mid();
    chk_resp("apb_err1", 1'b0, 1'b1);
    cyc();
    bus.slv_hreadyout = '1;
    mid();
    chk_resp("apb_err2", 1'b1, 1'b1);
    cyc();
    bus.slv_hresp = '0;
    mid();
    chk_resp("apb_after", 1'b1, 1'b0);
    checks++;
    if (err_count !== 8'd5) begin errors++; $display("FAIL apb_not_counted: got %0d expected 5", err_count); end
  endtask

  task automatic test_reset_in_err1();
    cyc();
    addr_phase(5'b00000, 1'b1, HTRANS_NONSEQ, 32'h3000_0040);
    mid();
    cyc();
    idle_inputs(32'h0);
    mid();
    chk_resp("rst_err1_pre", 1'b0, 1'b1);
    hreset = 1'b1;
    cyc();
    hreset = 1'b0;
    mid();
    chk_resp("rst_err1_post", 1'b1, 1'b0);
    checks++;
    if (err_count !== 8'd0 || err_addr !== 32'h0 || sat_count !== 2'd0) begin
      errors++; $display("FAIL rst_err1_debug: count %0d addr %h sat %0d expected 0 00000000 0",
                         err_count, err_addr, sat_count);
    end
    cyc();
    mid();
    chk_resp("rst_err1_idle", 1'b1, 1'b0);
    checks++;
    if (err_count !== 8'd0) begin errors++; $display("FAIL rst_err1_no_inc: got %0d expected 0", err_count); end
  endtask

  initial begin
    test_reset();
    test_flash_read();
    test_sdram_wait();
    test_unmapped();
    test_back_to_back();
    test_invalid_select();
    test_saturation();
    test_slave_error();
    test_reset_in_err1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cmsdk_mcu_ahb_slave_mux.md
Name: cmsdk_mcu_ahb_slave_mux

Overview:
- Data-phase response multiplexer placed directly downstream of the system address decoder on the CPU AHB-Lite bus.
- Registers the decoder's one-hot select vector during the address phase.
- In the data phase, routes the selected slave's HRDATA/HREADYOUT/HRESP back to the master.
- Contains the built-in default slave: a two-cycle ERROR for unmapped active transfers, plus an error counter and last-error-address capture for debug.

Parameters:
- NUM_SLV, 5, number of external slave ports. Slot order: 0 flash, 1 dma, 2 sdram, 3 apbbus, 4 cpu2.
- DW, 32, data width.
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- hclk  in  1  bus clock.
- hreset  in  1  synchronous, active-high reset.
- haddr  in  32  address-phase HADDR.
- htrans  in  2  address-phase HTRANS.
- hready  in  1  bus HREADY (fed back from hready_out at top level).
- hsel_vec  in  NUM_SLV  one-hot external selects from the decoder.
- defslv_hsel  in  1  unmapped-region select from the decoder.
- slv_hrdata  in  NUM_SLV*DW  concatenated slave read data; slot i at bits [i*DW +: DW].
- slv_hreadyout  in  NUM_SLV  per-slave HREADYOUT.
- slv_hresp  in  NUM_SLV  per-slave HRESP.
- hrdata  out  DW  muxed read data to master.
- hready_out  out  1  muxed HREADY to master and slaves.
- hresp  out  1  muxed HRESP to master.
- err_count  out  ERRCNT_W  saturating count of default-slave ERROR responses.
- err_addr  out  32  HADDR of the most recent default-slave errored transfer.

Behaviour:
- Address-phase capture: when hready=1, register sel_q <= {defslv_hsel, hsel_vec}. When hready=0, sel_q holds.
- Input validity: if the captured vector is not one-hot (zero or multiple bits set), treat it as a default-slave select.
- Data-phase mux, combinational from sel_q:
  - External slot i selected: hrdata = slot i data, hready_out = slv_hreadyout[i], hresp = slv_hresp[i].
  - Default slot selected: hrdata = 0, and hready_out/hresp come from the default-slave FSM.
- Default-slave FSM states: IDLE, ERR1, ERR2.
  - IDLE: default-slave outputs hreadyout=1, hresp=0. On hready=1 with effective default select and htrans[1]=1 (NONSEQ or SEQ), go to ERR1 and latch haddr into err_addr.
  - Default select with htrans IDLE or BUSY: zero-wait OKAY, stay in IDLE.
  - ERR1: hreadyout=0, hresp=1. Always go to ERR2 next cycle.
  - ERR2: hreadyout=1, hresp=1. err_count increments on this cycle, saturating at all-ones.
  - Leaving ERR2: if hready=1 and another active default-selected transfer is present, go to ERR1 (back-to-back errors, err_addr updated). Otherwise go to IDLE.
  - An address phase arriving during ERR1 is not sampled, because hready=0 on the bus.
- Reset, synchronous, hreset=1 at a hclk edge:
  - sel_q selects the default slot.
  - FSM goes to IDLE.
  - err_count=0, err_addr=0.
  - Resulting outputs: hrdata=0, hready_out=1, hresp=0.
  - Reset during ERR1 or ERR2 aborts the error response; the counter does not increment.
- Latency: zero added cycles for external slaves (pure mux after the registered select). The default slave always adds exactly one wait state per active transfer.
- Slave wait states: while the selected slave drives hreadyout=0, sel_q is frozen. The next address phase is captured only on the cycle hready_out=1.

Decomposition:
- Shared package cmsdk_mcu_ahb_pkg:
  - HTRANS encodings (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11).
  - Slot index constants (SLOT_FLASH=0 … SLOT_CPU2=4, SLOT_DEF=5).
  - Default-slave FSM state encoding.
- One natural sub-module: cmsdk_mcu_ahb_default_slave. It holds the FSM, err_count and err_addr, and outputs its own hreadyout/hresp. The mux instantiates it.

Test Plan:
- Reset: hold hreset=1 for 2 cycles -> hready_out=1, hresp=0, hrdata=0, err_count=0, err_addr=0.
- Flash read, zero-wait: address phase with hsel_vec=5'b00001, htrans=NONSEQ, hready=1; next cycle slot0 data=0xDEADBEEF with hreadyout=1 -> hrdata=0xDEADBEEF, hready_out=1, hresp=0.
- SDRAM with 2 wait states: hsel_vec=5'b00100, slot2 hreadyout=0,0,1 -> hready_out=0,0,1. A new select presented on the stall cycles is ignored; the next phase is captured on the third cycle.
- Unmapped NONSEQ: defslv_hsel=1 at haddr=0x3000_0010 -> next cycle hready_out=0/hresp=1, then hready_out=1/hresp=1. After that, err_count=1 and err_addr=0x3000_0010.
- Back-to-back unmapped SEQ transfers at 0x3000_0010 and 0x3000_0014 -> two complete ERR1/ERR2 pairs with no IDLE cycle between them. err_count=2, err_addr=0x3000_0014. An IDLE transfer to the unmapped region gives OKAY with no wait state, and the count is unchanged.
- Mixed checks:
  - Counter saturation with ERRCNT_W=2: after 5 errors, err_count=3.
  - Reset asserted during ERR1: next cycle hready_out=1, hresp=0, err_count unchanged at 0.
